ti_trav_stack: RTL and testbench

- Multi-lane BVH traversal stack for the ray/triangle intersection (ti) unit.
- Holds NUM_LANES independent LIFO stacks of node indices, one per in-flight ray.
- Supports single and paired (far/near child) pushes, pops with a registered response, per-lane clear, and sticky overflow reporting.
- Sits between the traversal FSM (pop/push/clear decisions) and the node fetch path (the popped index feeds the memory request).

---
 rtl/ti_trav_stack.sv | 206 ++++++++++++++++++++
 tb/tb_ti_trav_stack.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ti_trav_stack.sv
// rtl/ti_trav_stack.sv - multi-lane BVH traversal stack with registered pop response
// Optional ring-buffer overflow mode when TI_STACK_WRAP_EN is defined.
module ti_trav_stack #(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 16,
  parameter int IDX_BITS  = 32,
  parameter int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LANE_BITS-1:0] req_lane,
  input  logic [1:0]           req_op,
  input  logic [IDX_BITS-1:0]  req_idx0,
  input  logic [IDX_BITS-1:0]  req_idx1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [LANE_BITS-1:0] rsp_lane,
  output logic [IDX_BITS-1:0]  rsp_idx,
  output logic                 rsp_empty,
  output logic                 rsp_ovf,
  output logic [NUM_LANES-1:0] empty_mask,
  output logic [NUM_LANES-1:0] ovf_mask
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_FULL1 = SPW'(DEPTH - 1);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_PUSH1 = 2'd1,
    OP_PUSH2 = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  logic [SPW-1:0]      sp_q  [NUM_LANES];
  logic                ovf_q [NUM_LANES];
  logic [IDX_BITS-1:0] mem_q [NUM_LANES][DEPTH];

  logic                rsp_valid_q, rsp_empty_q, rsp_ovf_q;
  logic [LANE_BITS-1:0] rsp_lane_q;
  logic [IDX_BITS-1:0] rsp_idx_q;

  op_e            op;
  logic           req_fire;
  logic [SPW-1:0] sel_sp, sp_d, wr0_off, wr1_off, rd_off;
  logic           sel_ovf, ovf_d, wr0_en, wr1_en;
  logic [AW-1:0]  wr0_addr, wr1_addr, rd_addr;
  logic [IDX_BITS-1:0] rd_data;

`ifdef TI_STACK_WRAP_EN
  logic [AW-1:0] base_q [NUM_LANES];
  logic [AW-1:0] sel_base, base_d;

  // Offset from the ring base, folded back into 0..DEPTH-1.
  function automatic logic [AW-1:0] ring(input logic [AW-1:0] b, input logic [SPW-1:0] off);
    logic [SPW:0] s;
    s = (SPW+1)'(b) + (SPW+1)'(off);
    if (s >= (SPW+1)'(DEPTH)) s = s - (SPW+1)'(DEPTH);
    return AW'(s);
  endfunction
`endif

  assign op        = op_e'(req_op);
  assign req_ready = reset && (!rsp_valid_q || rsp_ready);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    sel_sp  = sp_q[req_lane];
    sel_ovf = ovf_q[req_lane];
    sp_d    = sel_sp;
    ovf_d   = sel_ovf;
    wr0_en  = 1'b0;
    wr1_en  = 1'b0;
    wr0_off = sel_sp;
    wr1_off = sel_sp + SPW'(1);
    rd_off  = (sel_sp == '0) ? '0 : sel_sp - SPW'(1);
`ifdef TI_STACK_WRAP_EN
    sel_base = base_q[req_lane];
    base_d   = sel_base;
`endif
    case (op)
      OP_CLEAR: begin
        sp_d  = '0;
        ovf_d = 1'b0;
      end
      OP_PUSH1: begin
        if (sel_sp != SP_FULL) begin
          wr0_en = 1'b1;
          sp_d   = sel_sp + SPW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef TI_STACK_WRAP_EN
          wr0_en  = 1'b1;
          wr0_off = '0;
          base_d  = ring(sel_base, SPW'(1));
`endif
        end
      end
      OP_PUSH2: begin
        if (sel_sp < SP_FULL1) begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
          sp_d   = sel_sp + SPW'(2);
        end else if (sel_sp == SP_FULL1) begin
          wr0_en = 1'b1;
          ovf_d  = 1'b1;
          sp_d   = SP_FULL;
`ifdef TI_STACK_WRAP_EN
          wr1_en  = 1'b1;
          wr1_off = '0;
          base_d  = ring(sel_base, SPW'(1));
`endif
        end else begin
          ovf_d = 1'b1;
`ifdef TI_STACK_WRAP_EN
          wr0_en  = 1'b1;
          wr1_en  = 1'b1;
          wr0_off = '0;
          wr1_off = SPW'(1);
          base_d  = ring(sel_base, SPW'(2));
`endif
        end
      end
      default: begin
        if (sel_sp != '0) sp_d = sel_sp - SPW'(1);
      end
    endcase
  end

`ifdef TI_STACK_WRAP_EN
  assign wr0_addr = ring(sel_base, wr0_off);
  assign wr1_addr = ring(sel_base, wr1_off);
  assign rd_addr  = ring(sel_base, rd_off);
`else
  assign wr0_addr = AW'(wr0_off);
  assign wr1_addr = AW'(wr1_off);
  assign rd_addr  = AW'(rd_off);
`endif
  assign rd_data = mem_q[req_lane][rd_addr];

  always_ff @(posedge clk) begin
    if (req_fire) begin
      if (wr0_en) mem_q[req_lane][wr0_addr] <= req_idx0;
      if (wr1_en) mem_q[req_lane][wr1_addr] <= req_idx1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        sp_q[l]  <= '0;
        ovf_q[l] <= 1'b0;
`ifdef TI_STACK_WRAP_EN
        base_q[l] <= '0;
`endif
      end
      rsp_valid_q <= 1'b0;
      rsp_lane_q  <= '0;
      rsp_idx_q   <= '0;
      rsp_empty_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      if (req_fire) begin
        sp_q[req_lane]  <= sp_d;
        ovf_q[req_lane] <= ovf_d;
`ifdef TI_STACK_WRAP_EN
        base_q[req_lane] <= base_d;
`endif
      end
      // A new pop reloads the register even while the old response drains.
      if (req_fire && op == OP_POP) begin
        rsp_valid_q <= 1'b1;
        rsp_lane_q  <= req_lane;
        rsp_idx_q   <= (sel_sp == '0) ? '0 : rd_data;
        rsp_empty_q <= (sel_sp == '0);
        rsp_ovf_q   <= sel_ovf;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_lane_q  <= '0;
        rsp_idx_q   <= '0;
        rsp_empty_q <= 1'b0;
        rsp_ovf_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    empty_mask = '0;
    ovf_mask   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      empty_mask[l] = (sp_q[l] == '0);
      ovf_mask[l]   = ovf_q[l];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_lane  = rsp_lane_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_empty = rsp_empty_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_ti_trav_stack.sv
// tb/tb_ti_trav_stack.sv - self-checking bench for ti_trav_stack with a queue-based model
module tb_ti_trav_stack;
  localparam int NL = 4;
  localparam int D  = 16;
  localparam int IW = 32;
  localparam int LB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [LB-1:0] req_lane;
  logic [1:0]    req_op;
  logic [IW-1:0] req_idx0, req_idx1;
  logic          rsp_valid, rsp_ready;
  logic [LB-1:0] rsp_lane;
  logic [IW-1:0] rsp_idx;
  logic          rsp_empty, rsp_ovf;
  logic [NL-1:0] empty_mask, ovf_mask;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ti_trav_stack #(.NUM_LANES(NL), .DEPTH(D), .IDX_BITS(IW), .LANE_BITS(LB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_lane(req_lane), .req_op(req_op),
    .req_idx0(req_idx0), .req_idx1(req_idx1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane), .rsp_idx(rsp_idx),
    .rsp_empty(rsp_empty), .rsp_ovf(rsp_ovf),
    .empty_mask(empty_mask), .ovf_mask(ovf_mask)
  );

  // Model: one queue per lane, back of queue is top of stack.
  logic [IW-1:0] mq [NL][$];
  bit            movf [NL];
  bit            mrv, mempty, movfr, acc;
  logic [LB-1:0] mlane;
  logic [IW-1:0] midx;

  function automatic void mpush(input int l, input logic [IW-1:0] v);
    if (mq[l].size() < D) mq[l].push_back(v);
    else begin
      movf[l] = 1'b1;
`ifdef TI_STACK_WRAP_EN
      void'(mq[l].pop_front());
      mq[l].push_back(v);
`endif
    end
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < NL; l++) begin
        mq[l].delete();
        movf[l] = 1'b0;
      end
      mrv = 1'b0; mempty = 1'b0; movfr = 1'b0; mlane = '0; midx = '0;
    end else begin
      acc = req_valid && (!mrv || rsp_ready);
      if (acc && req_op == 2'd3) begin
        mrv = 1'b1;
        mlane = req_lane;
        movfr = movf[req_lane];
        if (mq[req_lane].size() == 0) begin
          midx = '0; mempty = 1'b1;
        end else begin
          midx = mq[req_lane].pop_back(); mempty = 1'b0;
        end
      end else if (rsp_ready) mrv = 1'b0;
      if (acc) begin
        case (req_op)
          2'd0: begin mq[req_lane].delete(); movf[req_lane] = 1'b0; end
          2'd1: mpush(int'(req_lane), req_idx0);
          2'd2: begin mpush(int'(req_lane), req_idx0); mpush(int'(req_lane), req_idx1); end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NL-1:0] em, om;
      for (int l = 0; l < NL; l++) begin
        em[l] = (mq[l].size() == 0);
        om[l] = movf[l];
      end
      check("req_ready", 64'(req_ready), 64'(reset && (!mrv || rsp_ready)));
      check("rsp_valid", 64'(rsp_valid), 64'(mrv));
      if (mrv) begin
        check("rsp_lane", 64'(rsp_lane), 64'(mlane));
        check("rsp_idx", 64'(rsp_idx), 64'(midx));
        check("rsp_empty", 64'(rsp_empty), 64'(mempty));
        check("rsp_ovf", 64'(rsp_ovf), 64'(movfr));
      end
      check("empty_mask", 64'(empty_mask), 64'(em));
      check("ovf_mask", 64'(ovf_mask), 64'(om));
    end
  end

  task automatic cyc(input bit v, input logic [1:0] op, input int lane,
                     input logic [IW-1:0] a, input logic [IW-1:0] b, input bit rr);
    req_valid = v; req_op = op; req_lane = lane[LB-1:0];
    req_idx0 = a; req_idx1 = b; rsp_ready = rr;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_lane = '0;
    req_idx0 = '0; req_idx1 = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lit_rst_ready", 64'(req_ready), 64'd0);
    check("lit_rst_valid", 64'(rsp_valid), 64'd0);
    check("lit_rst_empty", 64'(empty_mask), 64'hF);
    chk_en = 1'b1;
    reset = 1'b1;
    #1;

    // Lane 0 basic LIFO and empty pop
    cyc(1, 2'd1, 0, 5, 0, 1);
    cyc(1, 2'd1, 0, 6, 0, 1);
    cyc(1, 2'd3, 0, 0, 0, 1);
    check("lit_pop6", 64'(rsp_idx), 64'd6);
    cyc(1, 2'd3, 0, 0, 0, 1);
    check("lit_pop5", 64'(rsp_idx), 64'd5);
    cyc(1, 2'd3, 0, 0, 0, 1);
    check("lit_pop_empty", 64'(rsp_empty), 64'd1);
    check("lit_pop_empty_idx", 64'(rsp_idx), 64'd0);
    cyc(0, 2'd0, 0, 0, 0, 1);
    check("lit_lane0_empty", 64'(empty_mask), 64'hF);

    // Lane 2 paired push
    cyc(1, 2'd2, 2, 10, 11, 1);
    check("lit_push2_mask", 64'(empty_mask), 64'b1011);
    cyc(1, 2'd3, 2, 0, 0, 1);
    check("lit_pop11", 64'(rsp_idx), 64'd11);
    cyc(1, 2'd3, 2, 0, 0, 1);
    check("lit_pop10", 64'(rsp_idx), 64'd10);

    // Lane 1 overflow: sp==DEPTH-1 then PUSH2, then pushes at sp==DEPTH
    for (int i = 0; i < 15; i++) cyc(1, 2'd1, 1, 200 + i, 0, 1);
    cyc(1, 2'd2, 1, 100, 101, 1);
    check("lit_ovf_mask", 64'(ovf_mask), 64'b0010);
    cyc(1, 2'd3, 1, 0, 0, 1);
`ifdef TI_STACK_WRAP_EN
    check("lit_ovf_pop", 64'(rsp_idx), 64'd101);
`else
    check("lit_ovf_pop", 64'(rsp_idx), 64'd100);
`endif
    check("lit_ovf_rsp", 64'(rsp_ovf), 64'd1);
    cyc(1, 2'd1, 1, 300, 0, 1);
    cyc(1, 2'd2, 1, 301, 302, 1);
    cyc(1, 2'd1, 1, 303, 0, 1);
    cyc(1, 2'd3, 1, 0, 0, 1);
`ifdef TI_STACK_WRAP_EN
    check("lit_full_pop", 64'(rsp_idx), 64'd303);
`else
    check("lit_full_pop", 64'(rsp_idx), 64'd300);
`endif

    // Lane 3 backpressure and back-to-back pop
    cyc(1, 2'd1, 3, 8, 0, 1);
    cyc(1, 2'd1, 3, 7, 0, 1);
    cyc(1, 2'd3, 3, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("lit_hold_valid", 64'(rsp_valid), 64'd1);
      check("lit_hold_idx", 64'(rsp_idx), 64'd7);
      check("lit_hold_ready", 64'(req_ready), 64'd0);
      cyc(1, 2'd3, 3, 0, 0, 0);
    end
    req_valid = 1'b1; req_op = 2'd3; req_lane = 2'd3; rsp_ready = 1'b1;
    #1;
    check("lit_b2b_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lit_b2b_idx", 64'(rsp_idx), 64'd8);

    // CLEAR on overflowed lane 1, lane 0 holds one entry
    cyc(1, 2'd1, 0, 42, 0, 1);
    cyc(1, 2'd0, 1, 0, 0, 1);
    check("lit_clear_empty", 64'(empty_mask), 64'b1110);
    check("lit_clear_ovf", 64'(ovf_mask), 64'd0);

    // Reset with a pending response and lane 0 at sp=4
    cyc(1, 2'd0, 0, 0, 0, 1);
    cyc(1, 2'd2, 0, 1, 2, 1);
    cyc(1, 2'd2, 0, 3, 4, 1);
    cyc(1, 2'd3, 3, 0, 0, 0);
    check("lit_pre_rst_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b0;
    cyc(0, 2'd0, 0, 0, 0, 0);
    reset = 1'b1;
    check("lit_post_rst_valid", 64'(rsp_valid), 64'd0);
    check("lit_post_rst_empty", 64'(empty_mask), 64'hF);
    check("lit_post_rst_ovf", 64'(ovf_mask), 64'd0);
    cyc(0, 2'd0, 0, 0, 0, 1);
    cyc(0, 2'd0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
